muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the multiply/divide resource behind the ALU's MULT, MULTU, DIV, DIVU, MTHI and MTLO operations. It owns the architectural HI/LO registers. It runs a 32-step shift-add multiply or restoring divide and raises a busy flag so the core can stall MFHI/MFLO and further mult/div issue. It sits beside the ALU in the execute stage and is driven by the decoded ALU control.

---
 rtl/muldiv_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle multiply/divide engine that owns the architectural HI/LO
// registers. A 32-step shift-add multiply or restoring divide runs on private
// working registers. HI/LO only change on an MTHI/MTLO write or at the final
// sign-fix step.
//
// Ports
//   iCLK        in   system clock, rising edge
//   iRST_n      in   asynchronous active-low reset
//   iStart      in   begin an operation (accepted only when idle)
//   iOp[1:0]    in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   iA, iB      in   rs/rt operands (iA dividend, iB divisor)
//   iMTHI/iMTLO in   write iA into HI / LO while idle
//   iFlush      in   abort the operation in flight / squash idle requests
//   oHI, oLO    out  architectural HI / LO
//   oBusy       out  operation in progress (registered)
//   oDone       out  one-cycle pulse when new HI/LO values first appear
//   oDbgState   out  FSM state: 0 IDLE, 1 RUN, 2 FIX
//
// Handshake: iStart is a single-cycle request. It is consumed on the edge
// where oBusy=0 and iFlush=0. It is ignored on every other edge, so the
// requester must hold off until oBusy=0.
// -----------------------------------------------------------------------------
module muldiv_sequencer (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iStart,
  input  logic [1:0]  iOp,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iMTHI,
  input  logic        iMTLO,
  input  logic        iFlush,
  output logic [31:0] oHI,
  output logic [31:0] oLO,
  output logic        oBusy,
  output logic        oDone,
  output logic [1:0]  oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;   // negate product / quotient at FIX
  logic        neg_rem_q, neg_rem_d;   // remainder takes the dividend sign
  logic [31:0] mcand_q, mcand_d;       // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;           // {partial, multiplier} or {rem, quo}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Operand preparation at accept time.
  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign op_signed = ~iOp[0];
  assign a_neg     = op_signed & iA[31];
  assign b_neg     = op_signed & iB[31];
  // Magnitude of 0x80000000 stays 0x80000000, read as unsigned.
  assign a_mag     = a_neg ? (~iA + 32'd1) : iA;
  assign b_mag     = b_neg ? (~iB + 32'd1) : iB;

  // Multiply step: the 33-bit sum keeps the carry that shifts into bit 63.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mcand_q : 32'd0)};

  // Divide step: the remainder after the left shift needs 33 bits before the
  // trial subtract. When the trial subtract succeeds, the result fits in 32
  // bits. With a zero divisor, the remainder simply collects the dividend.
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_rem;
  assign div_shift = acc_q[63:31];
  assign div_ok    = (div_shift >= {1'b0, mcand_q});
  assign div_rem   = div_shift[31:0] - mcand_q;

  // Sign fix.
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed, rem_fixed;
  assign prod_fixed = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fixed  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fixed  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (iStart && !iFlush) state_d = ST_RUN;
      ST_RUN: begin
        if (iFlush)              state_d = ST_IDLE;
        else if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (Moore, from registered state only)
  always_comb begin
    oBusy     = (state_q != ST_IDLE);
    oDbgState = state_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!iFlush) begin
          if (iStart) begin
            // iStart wins over a same-cycle MTHI/MTLO.
            is_div_d  = iOp[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = 5'd0;
            if (iOp[1]) begin
              mcand_d = b_mag;
              acc_d   = {32'd0, a_mag};
            end else begin
              mcand_d = a_mag;
              acc_d   = {32'd0, b_mag};
            end
          end else begin
            if (iMTHI) hi_d = iA;
            if (iMTLO) lo_d = iA;
          end
        end
      end

      ST_RUN: begin
        if (!iFlush) begin
          cnt_d = cnt_q + 5'd1;
          if (is_div_q) begin
            if (div_ok) acc_d = {div_rem, acc_q[30:0], 1'b1};
            else        acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
        end
      end

      ST_FIX: begin
        if (!iFlush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fixed;
            lo_d = quo_fixed;
          end else begin
            hi_d = prod_fixed[63:32];
            lo_d = prod_fixed[31:0];
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign oHI   = hi_q;
  assign oLO   = lo_q;
  assign oDone = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic        iStart;
  logic [1:0]  iOp;
  logic [31:0] iA, iB;
  logic        iMTHI, iMTLO, iFlush;
  logic [31:0] oHI, oLO;
  logic        oBusy, oDone;
  logic [1:0]  oDbgState;

  always #5 iCLK = ~iCLK;

  muldiv_sequencer dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iStart    (iStart),
    .iOp       (iOp),
    .iA        (iA),
    .iB        (iB),
    .iMTHI     (iMTHI),
    .iMTLO     (iMTLO),
    .iFlush    (iFlush),
    .oHI       (oHI),
    .oLO       (oLO),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oDbgState (oDbgState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] hi_m, lo_m;          // reference HI/LO
  logic [63:0] exp_q[$];            // {HI, LO} results in completion order

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic from the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sgn;
    longint      sa, sb, sp;
    logic [63:0] p;
    logic [31:0] am, bm, q, r;
    sgn = ~op[0];
    if (!op[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        p  = sp;
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      return p;
    end
    am = (sgn && a[31]) ? -a : a;
    bm = (sgn && b[31]) ? -b : b;
    if (bm == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = am;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (sgn && (a[31] ^ b[31])) q = -q;
    if (sgn && a[31])           r = -r;
    return {r, q};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at #1 after a rising edge, DUT idle)
  // ---------------------------------------------------------------------------
  task automatic clear_inputs();
    iStart = 1'b0; iMTHI = 1'b0; iMTLO = 1'b0; iFlush = 1'b0;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_mt);
    int          cyc;
    int          dones;
    logic [63:0] exp;
    exp_q.push_back(model(op, a, b));
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    iMTHI = with_mt; iMTLO = with_mt;
    tick();                                   // E0
    clear_inputs();
    iA = $urandom; iB = $urandom; iOp = 2'($urandom_range(0, 3));
    if (with_mt) begin
      chk("start_over_mt_hi", {32'd0, oHI}, {32'd0, hi_m});
      chk("start_over_mt_lo", {32'd0, oLO}, {32'd0, lo_m});
    end
    cyc = 0; dones = 0;
    while (oBusy && cyc < 100) begin
      if (oDone) dones++;
      if (cyc == 16) begin
        chk("hold_hi", {32'd0, oHI}, {32'd0, hi_m});
        chk("hold_lo", {32'd0, oLO}, {32'd0, lo_m});
      end
      if (disturb && cyc == 5) begin
        iStart = 1'b1; iMTLO = 1'b1; iMTHI = 1'b1; iA = $urandom;
      end else begin
        iStart = 1'b0; iMTLO = 1'b0; iMTHI = 1'b0;
      end
      tick();
      cyc++;
    end
    clear_inputs();
    exp = exp_q.pop_front();
    chk("busy_cycles", 64'(cyc), 64'd33);
    chk("done_during_busy", 64'(dones), 64'd0);
    chk("done_pulse", {63'd0, oDone}, 64'd1);
    chk("result_hi", {32'd0, oHI}, {32'd0, exp[63:32]});
    chk("result_lo", {32'd0, oLO}, {32'd0, exp[31:0]});
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    tick();
    chk("done_one_cycle", {63'd0, oDone}, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int dones;
    logic [31:0] ra, rb;
    clear_inputs();
    iOp = 2'd0; iA = 32'd0; iB = 32'd0;
    iRST_n = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1;
    chk("rst_hi", {32'd0, oHI}, 64'd0);
    chk("rst_lo", {32'd0, oLO}, 64'd0);
    chk("rst_busy", {63'd0, oBusy}, 64'd0);
    chk("rst_done", {63'd0, oDone}, 64'd0);
    chk("rst_state", {62'd0, oDbgState}, 64'd0);
    tick();
    tick();
    iRST_n = 1'b1;

    // MULTU max x max
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu_max_hi", {32'd0, oHI}, {32'd0, 32'hFFFF_FFFE});
    chk("multu_max_lo", {32'd0, oLO}, {32'd0, 32'h0000_0001});
    // MULT -3 x 5
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0);
    chk("mult_neg_hi", {32'd0, oHI}, {32'd0, 32'hFFFF_FFFF});
    chk("mult_neg_lo", {32'd0, oLO}, {32'd0, 32'hFFFF_FFF1});
    // DIV -7 / 2
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("div_neg_hi", {32'd0, oHI}, {32'd0, 32'hFFFF_FFFF});
    chk("div_neg_lo", {32'd0, oLO}, {32'd0, 32'hFFFF_FFFD});
    // DIV most-negative / -1
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("div_ovf_hi", {32'd0, oHI}, 64'd0);
    chk("div_ovf_lo", {32'd0, oLO}, {32'd0, 32'h8000_0000});
    // DIVU by zero
    run_op(2'b11, 32'h0000_1234, 32'd0, 0, 0);
    chk("divu_zero_hi", {32'd0, oHI}, {32'd0, 32'h0000_1234});
    chk("divu_zero_lo", {32'd0, oLO}, {32'd0, 32'hFFFF_FFFF});
    // Signed DIV by zero, negative dividend
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);

    // MTHI + MTLO together, then MTHI alone
    iMTHI = 1'b1; iMTLO = 1'b1; iA = 32'h1357_9BDF;
    tick();
    clear_inputs();
    hi_m = 32'h1357_9BDF; lo_m = 32'h1357_9BDF;
    chk("mt_both_hi", {32'd0, oHI}, {32'd0, hi_m});
    chk("mt_both_lo", {32'd0, oLO}, {32'd0, lo_m});
    iMTHI = 1'b1; iA = 32'hAAAA_5555;
    tick();
    clear_inputs();
    hi_m = 32'hAAAA_5555;
    chk("mthi", {32'd0, oHI}, {32'd0, hi_m});
    chk("mthi_lo_kept", {32'd0, oLO}, {32'd0, lo_m});

    // MULT 2x3 flushed at E10, restart at E11
    iStart = 1'b1; iOp = 2'b00; iA = 32'd2; iB = 32'd3;
    tick();                                   // E0
    clear_inputs();
    dones = 0;
    repeat (9) begin
      tick();
      if (oDone) dones++;
    end
    iFlush = 1'b1;
    tick();                                   // E10
    iFlush = 1'b0;
    chk("flush_busy", {63'd0, oBusy}, 64'd0);
    chk("flush_done", {63'd0, oDone}, 64'd0);
    chk("flush_done_seen", 64'(dones), 64'd0);
    chk("flush_hi", {32'd0, oHI}, {32'd0, 32'hAAAA_5555});
    chk("flush_lo", {32'd0, oLO}, {32'd0, lo_m});
    run_op(2'b00, 32'd2, 32'd3, 0, 0);        // sampled at E11

    // Flush in IDLE squashes start and MTLO
    iStart = 1'b1; iMTLO = 1'b1; iFlush = 1'b1; iOp = 2'b01; iA = $urandom;
    tick();
    clear_inputs();
    chk("idle_flush_busy", {63'd0, oBusy}, 64'd0);
    chk("idle_flush_lo", {32'd0, oLO}, {32'd0, lo_m});
    tick();
    chk("idle_flush_busy2", {63'd0, oBusy}, 64'd0);

    // DIVU with start/MT pulses while busy, then start + MTHI together
    run_op(2'b11, $urandom, 32'($urandom_range(1, 1000)), 1, 0);
    run_op(2'b11, $urandom, $urandom, 0, 1);

    // Reset at E20 of a DIVU
    iStart = 1'b1; iOp = 2'b11; iA = 32'hDEAD_BEEF; iB = 32'd7;
    tick();                                   // E0
    clear_inputs();
    repeat (19) tick();
    @(posedge iCLK);                          // E20
    iRST_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, oBusy}, 64'd0);
    chk("mid_rst_hi", {32'd0, oHI}, 64'd0);
    chk("mid_rst_lo", {32'd0, oLO}, 64'd0);
    chk("mid_rst_state", {62'd0, oDbgState}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    tick();
    iRST_n = 1'b1;
    run_op(2'b11, 32'd100, 32'd7, 0, 0);      // first edge after release

    // Random operations with interleaved MTHI/MTLO
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        iMTHI = 1'($urandom_range(0, 1)); iMTLO = 1'($urandom_range(0, 1)); iA = $urandom;
        if (iMTHI) hi_m = iA;
        if (iMTLO) lo_m = iA;
        tick();
        clear_inputs();
        chk("rand_mt_hi", {32'd0, oHI}, {32'd0, hi_m});
        chk("rand_mt_lo", {32'd0, oLO}, {32'd0, lo_m});
      end
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 0, 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
